// File: rtl/aftab_div_pkg.sv
// Shared op and state encodings for the AFTAB divider sequencer and its bench.
package aftab_div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } div_state_e;

endpackage

// File: rtl/aftab_div_fixup.sv
// Divide-by-zero / signed-overflow detection and final result selection
// (RISC-V semantics); purely combinational.
module aftab_div_fixup
    import aftab_div_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic [1:0]     op,
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    input  logic [LEN-1:0] quotient,
    input  logic [LEN-1:0] remainder,
    output logic           special,
    output logic [LEN-1:0] result
);

    logic div_zero_s;
    logic overflow_s;
    logic op_signed_s;

    // Classify the operands and pick quotient, remainder or the fixed value.
    always_comb begin
        op_signed_s = (op == OP_DIV) || (op == OP_REM);
        div_zero_s  = (b == {LEN{1'b0}});
        overflow_s  = op_signed_s
                      && (a == {1'b1, {(LEN-1){1'b0}}})
                      && (b == {LEN{1'b1}});
        special     = div_zero_s || overflow_s;
        if (op[1] == 1'b0) begin
            if (div_zero_s) begin
                result = {LEN{1'b1}};
            end else if (overflow_s) begin
                result = a;
            end else begin
                result = quotient;
            end
        end else begin
            if (div_zero_s) begin
                result = a;
            end else if (overflow_s) begin
                result = {LEN{1'b0}};
            end else begin
                result = remainder;
            end
        end
    end

endmodule

// File: rtl/aftab_div_sequencer.sv
// Request/response sequencer in front of a multi-cycle LEN+1 bit divider.
// Optional macro AFTAB_DIV_SPECIAL_BYPASS_EN: resolve special cases without the divider.
module aftab_div_sequencer
    import aftab_div_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_op,
    input  logic [LEN-1:0] req_a,
    input  logic [LEN-1:0] req_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [LEN-1:0] res_data,
    output logic [LEN:0]   div_dividend,
    output logic [LEN:0]   div_divisor,
    output logic           div_start,
    output logic           div_signed_flag,
    input  logic           div_ready,
    input  logic [LEN:0]   div_quotient,
    input  logic [LEN:0]   div_remainder
);

    div_state_e     state_r;
    div_state_e     next_state_s;
    logic [1:0]     op_r;
    logic [LEN-1:0] a_r;
    logic [LEN-1:0] b_r;
    logic           div_ready_q_r;
    logic           div_rise_s;
    logic           accept_s;

    logic           req_ready_r;
    logic           res_valid_r;
    logic [LEN-1:0] res_data_r;
    logic           div_start_r;
    logic [LEN:0]   div_dividend_r;
    logic [LEN:0]   div_divisor_r;
    logic           div_signed_flag_r;

    logic           req_ready_nxt_s;
    logic           res_valid_nxt_s;
    logic           div_start_nxt_s;
    logic           res_load_s;

    logic [1:0]     fix_op_s;
    logic [LEN-1:0] fix_a_s;
    logic [LEN-1:0] fix_b_s;
    logic           fix_special_s;
    logic [LEN-1:0] fix_result_s;
    logic           unused_s;

    function automatic logic [LEN:0] extend(input logic [LEN-1:0] v, input logic zext);
        return zext ? {1'b0, v} : {v[LEN-1], v};
    endfunction

    assign accept_s   = req_valid && req_ready_r;
    assign div_rise_s = div_ready && !div_ready_q_r;
    assign unused_s   = ^{div_quotient[LEN], div_remainder[LEN]};

`ifdef AFTAB_DIV_SPECIAL_BYPASS_EN
    // In IDLE the fixup classifies the incoming request so it can skip the divider.
    assign fix_op_s = (state_r == ST_IDLE) ? req_op : op_r;
    assign fix_a_s  = (state_r == ST_IDLE) ? req_a  : a_r;
    assign fix_b_s  = (state_r == ST_IDLE) ? req_b  : b_r;
`else
    assign fix_op_s = op_r;
    assign fix_a_s  = a_r;
    assign fix_b_s  = b_r;
`endif

    aftab_div_fixup #(.LEN(LEN)) u_fixup (
        .op        (fix_op_s),
        .a         (fix_a_s),
        .b         (fix_b_s),
        .quotient  (div_quotient[LEN-1:0]),
        .remainder (div_remainder[LEN-1:0]),
        .special   (fix_special_s),
        .result    (fix_result_s)
    );

    // State register; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef AFTAB_DIV_SPECIAL_BYPASS_EN
                    if (fix_special_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_START;
                    end
`else
                    next_state_s = ST_START;
`endif
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (div_rise_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so that the handshake outputs are registered.
    always_comb begin
        req_ready_nxt_s = (next_state_s == ST_IDLE);
        res_valid_nxt_s = (next_state_s == ST_DONE);
        div_start_nxt_s = (next_state_s == ST_START);
        res_load_s      = (next_state_s == ST_DONE) && (state_r != ST_DONE);
    end

    // Operand capture, divider drive, result latch and div_ready edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_r       <= 1'b1;
            res_valid_r       <= 1'b0;
            res_data_r        <= {LEN{1'b0}};
            div_start_r       <= 1'b0;
            div_dividend_r    <= {(LEN+1){1'b0}};
            div_divisor_r     <= {(LEN+1){1'b0}};
            div_signed_flag_r <= 1'b0;
            op_r              <= 2'b00;
            a_r               <= {LEN{1'b0}};
            b_r               <= {LEN{1'b0}};
            div_ready_q_r     <= 1'b0;
        end else begin
            req_ready_r   <= req_ready_nxt_s;
            res_valid_r   <= res_valid_nxt_s;
            div_start_r   <= div_start_nxt_s;
            div_ready_q_r <= div_ready;
            if (accept_s) begin
                op_r              <= req_op;
                a_r               <= req_a;
                b_r               <= req_b;
                div_dividend_r    <= extend(req_a, req_op[0]);
                div_divisor_r     <= extend(req_b, req_op[0]);
                div_signed_flag_r <= ~req_op[0];
            end
            if (res_load_s) begin
                res_data_r <= fix_result_s;
            end
        end
    end

    assign req_ready       = req_ready_r;
    assign res_valid       = res_valid_r;
    assign res_data        = res_data_r;
    assign div_start       = div_start_r;
    assign div_dividend    = div_dividend_r;
    assign div_divisor     = div_divisor_r;
    assign div_signed_flag = div_signed_flag_r;

endmodule

// File: doc/aftab_div_sequencer.md
AFTAB_DIV_SEQUENCER -- requirements
Module: aftab_div_sequencer

Interface
REQ-001 SHALL have parameter: LEN, 32, operand/result width; the divider port width is LEN+1.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset, sampled on the rising clk edge.
REQ-004 SHALL have ports req_valid input 1, req_ready output 1, req_op input 2 (00 DIV, 01 DIVU, 10 REM, 11 REMU), req_a input LEN (dividend), req_b input LEN (divisor).
REQ-005 SHALL have ports res_valid output 1, res_ready input 1, res_data output LEN.
REQ-006 SHALL have divider-side ports div_dividend output LEN+1, div_divisor output LEN+1, div_start output 1, div_signed_flag output 1, div_ready input 1, div_quotient input LEN+1, div_remainder input LEN+1.

Function
REQ-007 SHALL implement states IDLE, START, WAIT, DONE, encoded in 2 bits.
REQ-008 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid&req_ready on a rising edge.
REQ-009 SHALL on acceptance register op, a and b, and compute div_dividend/div_divisor by sign extension of bit LEN-1 when op[0]=0 and zero extension when op[0]=1, with div_signed_flag = ~op[0]; IDLE->START.
REQ-010 SHALL assert div_start for exactly one cycle, in START, then go START->WAIT; div operands and div_signed_flag SHALL stay stable from START until leaving WAIT.
REQ-011 SHALL leave WAIT only on a rising edge of div_ready (current sample 1, previous-cycle sample 0); a div_ready already high from a prior operation SHALL be ignored.
REQ-012 SHALL on leaving WAIT latch res_data = div_quotient[LEN-1:0] for op[1]=0, div_remainder[LEN-1:0] for op[1]=1, after special-case fixup (REQ-013/014); WAIT->DONE.
REQ-013 SHALL for divisor==0: DIV/DIVU result all ones; REM/REMU result = dividend (RISC-V rule).
REQ-014 SHALL for signed overflow (DIV/REM, a = 1 followed by LEN-1 zeros, b = all ones): DIV result = a, REM result = 0.
REQ-015 SHALL assert res_valid only in DONE, hold res_data stable until res_valid&res_ready, then DONE->IDLE; a new request SHALL be acceptable no earlier than the next cycle.
REQ-016 SHALL ignore req_valid in every state except IDLE; at most one operation is outstanding.

Reset
REQ-017 SHALL on rst force state IDLE, req_ready=1, res_valid=0, res_data=0, div_start=0, div_dividend=0, div_divisor=0, div_signed_flag=0, and clear the div_ready edge register.
REQ-018 SHALL, when rst asserts in START, WAIT or DONE, abandon the operation without emitting a result; rst has priority over all other events in the same cycle.

Configuration
REQ-019 SHALL, with AFTAB_DIV_SPECIAL_BYPASS_EN defined, resolve divide-by-zero and signed-overflow cases directly IDLE->DONE, without asserting div_start, with res_valid in the cycle after acceptance.
REQ-020 SHALL, without AFTAB_DIV_SPECIAL_BYPASS_EN, always run the divider and apply the REQ-013/014 fixup on its output; the results are identical in both builds, only latency differs.

Structure
REQ-021 SHALL place op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU) and state encodings in the shared aftab_div_pkg definitions, used by the sequencer and its bench.
REQ-022 SHALL isolate the special-case detection and result selection in one combinational sub-module, aftab_div_fixup.

Verification
REQ-023 SHALL test DIV a=-13 b=3 -> one div_start pulse, res_data=0xFFFFFFFC; REM same operands -> 0xFFFFFFFF.
REQ-024 SHALL test DIVU a=100 b=0 -> 0xFFFFFFFF; REMU a=100 b=0 -> 100; with the macro defined, div_start never asserts and res_valid rises one cycle after acceptance.
REQ-025 SHALL test DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-026 SHALL test backpressure: res_ready held 0 for 10 cycles in DONE -> res_valid and res_data stable, req_ready=0, second req_valid ignored.
REQ-027 SHALL test rst pulsed in WAIT -> next cycle IDLE, req_ready=1, res_valid=0; a later DIVU 7/2 -> 3.
REQ-028 SHALL test a stale-high div_ready at START -> no result until div_ready falls and rises again.
